// File: rtl/fuzzy_pkg.sv
// Shared definitions for the fuzzy processor: code markers, output term indices and the
// rule table used by the inference stage.
package fuzzy_pkg;

    localparam int unsigned W_PADRAO = 8;

    localparam logic [5:0] COD_START = 6'b010000;
    localparam logic [5:0] COD_END   = 6'b100000;

    localparam int unsigned N_TERMOS = 5;

    typedef enum logic [2:0] {
        NG = 3'd0,
        NP = 3'd1,
        ZE = 3'd2,
        PP = 3'd3,
        PG = 3'd4
    } termo_e;

    // Rk with k = 3*ee + dd maps to output term ee + dd (N=0, Z=1, P=2 on both inputs).
    function automatic logic [2:0] termo_saida(input logic [1:0] ee, input logic [1:0] dd);
        termo_e t;
        case ({ee, dd})
            4'b0000:                   t = NG;
            4'b0001, 4'b0100:          t = NP;
            4'b0010, 4'b0101, 4'b1000: t = ZE;
            4'b0110, 4'b1001:          t = PP;
            4'b1010:                   t = PG;
            default:                   t = NG;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/acumulador_termo.sv
// W-bit running-maximum register for one output term, with synchronous clear that
// takes priority over the update.
module acumulador_termo #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] valor_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valor_q <= '0;
        end else if (clr) begin
            valor_q <= '0;
        end else if (en && (d > valor_q)) begin
            valor_q <= d;
        end
    end

    assign q = valor_q;

endmodule

// File: rtl/inferencia_regras.sv
// Rule inference: min of input degrees per rule, max-aggregation per output term, publish on END.
// Optional rule counter output n_regras enabled by defining FUZZY_REGRA_CONT_EN.
module inferencia_regras
    import fuzzy_pkg::*;
#(
    parameter int unsigned W = W_PADRAO
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           EN_REGRAS,
    input  logic [5:0]     codigo,
    input  logic [3*W-1:0] mu_erro,
    input  logic [3*W-1:0] mu_derro,
`ifdef FUZZY_REGRA_CONT_EN
    output logic [3:0]     n_regras,
`endif
    output logic [5*W-1:0] forca,
    output logic           valido,
    output logic           erro_regra
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACUM  = 2'd1;
    localparam logic [1:0] DRENA = 2'd2;

    logic [1:0]     estado_q, estado_d;
    logic [3*W-1:0] me_q, md_q;
    logic           s1_val_q;
    logic [2:0]     s1_termo_q;
    logic [W-1:0]   s1_forca_q;
    logic           pub_q;
    logic           valido_q;
    logic           erro_q;
    logic [5*W-1:0] forca_q;
    logic [5*W-1:0] acc;

    logic [1:0]     ee, dd;
    logic           eh_start, eh_end, eh_regra, eh_invalido;
    logic           limpa, aceita;
    logic [W-1:0]   grau_e, grau_d, minimo;

    assign ee = codigo[3:2];
    assign dd = codigo[1:0];

    always_comb begin
        eh_start    = (codigo == COD_START);
        eh_end      = (codigo == COD_END);
        eh_regra    = (codigo[5:4] == 2'b00) && (ee != 2'b11) && (dd != 2'b11);
        eh_invalido = !(eh_start || eh_end || eh_regra);
        limpa       = EN_REGRAS && eh_start && ((estado_q == IDLE) || (estado_q == ACUM));
        aceita      = EN_REGRAS && eh_regra && (estado_q == ACUM);
    end

    // Degrees always come from the copies latched at Start, never the live inputs.
    always_comb begin
        case (ee)
            2'd0:    grau_e = me_q[0*W +: W];
            2'd1:    grau_e = me_q[1*W +: W];
            2'd2:    grau_e = me_q[2*W +: W];
            default: grau_e = '0;
        endcase
        case (dd)
            2'd0:    grau_d = md_q[0*W +: W];
            2'd1:    grau_d = md_q[1*W +: W];
            2'd2:    grau_d = md_q[2*W +: W];
            default: grau_d = '0;
        endcase
        minimo = (grau_e < grau_d) ? grau_e : grau_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:    if (EN_REGRAS && eh_start) estado_d = ACUM;
            ACUM:    if (EN_REGRAS && eh_end) estado_d = DRENA;
            DRENA:   estado_d = IDLE;
            default: estado_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q   <= IDLE;
            me_q       <= '0;
            md_q       <= '0;
            s1_val_q   <= 1'b0;
            s1_termo_q <= '0;
            s1_forca_q <= '0;
            erro_q     <= 1'b0;
            pub_q      <= 1'b0;
            valido_q   <= 1'b0;
            forca_q    <= '0;
        end else begin
            estado_q <= estado_d;
            if (limpa) begin
                me_q <= mu_erro;
                md_q <= mu_derro;
            end
            s1_val_q <= aceita;
            if (aceita) begin
                s1_termo_q <= termo_saida(ee, dd);
                s1_forca_q <= minimo;
            end
            if (limpa) begin
                erro_q <= 1'b0;
            end else if (EN_REGRAS && (estado_q == ACUM) && eh_invalido) begin
                erro_q <= 1'b1;
            end
            // DRENA lets the last stage-1 entry land before the copy to forca.
            pub_q    <= (estado_q == DRENA);
            valido_q <= pub_q;
            if (pub_q) begin
                forca_q <= acc;
            end
        end
    end

    // A clear on restart wins over any stage-1 entry landing the same edge.
    for (genvar k = 0; k < int'(N_TERMOS); k++) begin : g_acc
        acumulador_termo #(
            .W(W)
        ) u_acc (
            .clk(clk),
            .rst(rst),
            .clr(limpa),
            .en (s1_val_q && (s1_termo_q == 3'(k))),
            .d  (s1_forca_q),
            .q  (acc[k*W +: W])
        );
    end

`ifdef FUZZY_REGRA_CONT_EN
    logic [3:0] cont_q;
    logic [3:0] n_regras_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cont_q     <= '0;
            n_regras_q <= '0;
        end else begin
            if (limpa) begin
                cont_q <= '0;
            end else if (aceita && (cont_q != 4'hF)) begin
                cont_q <= cont_q + 4'd1;
            end
            if (pub_q) begin
                n_regras_q <= cont_q;
            end
        end
    end

    assign n_regras = n_regras_q;
`endif

    assign forca      = forca_q;
    assign valido     = valido_q;
    assign erro_regra = erro_q;

endmodule
